// File: rtl/lmc_r60.sv
// lmc_r60: Little-Man-Computer trainer core with a push-button loaded program RAM,
// an accumulator datapath and a LOAD/FETCH/EXEC/HALT sequencer.
//
// Ports:
//   timer555    - system clock, all state changes on the rising edge
//   reset_count - synchronous active-high reset (RAM contents are kept)
//   run         - 0 = load mode, 1 = run mode (level)
//   RAM_button  - load strobe; one write per sampled rising edge
//   data_in     - word written at `counter` in load mode
//   counter     - load address in LOAD, program counter otherwise
//   RAM_out     - combinational read of mem[counter]
//   Acc_out     - accumulator
//   carry       - carry of last ADD / borrow of last SUB
//   out_data    - value latched by OUT
//   out_valid   - one-cycle pulse after each OUT
//   halted      - high while in HALT
module lmc_r60 #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  timer555,
    input  logic                  reset_count,
    input  logic                  run,
    input  logic                  RAM_button,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] counter,
    output logic [DATA_WIDTH-1:0] RAM_out,
    output logic [DATA_WIDTH-1:0] Acc_out,
    output logic                  carry,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  halted
);

    typedef enum logic [1:0] {StLoad, StFetch, StExec, StHalt} state_e;

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpAdd = 3'd1;
    localparam logic [2:0] OpSub = 3'd2;
    localparam logic [2:0] OpSta = 3'd3;
    localparam logic [2:0] OpLda = 3'd4;
    localparam logic [2:0] OpBra = 3'd5;
    localparam logic [2:0] OpBrz = 3'd6;
    localparam logic [2:0] OpOut = 3'd7;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] counter_q, counter_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  btn_q;
    // Only the opcode and operand address of the instruction word are kept;
    // the middle bits carry no meaning.
    logic [2:0]            ir_opc_q, ir_opc_d;
    logic [ADDR_WIDTH-1:0] ir_addr_q, ir_addr_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] operand;

    assign RAM_out   = mem[counter_q];
    assign operand   = mem[ir_addr_q];
    assign counter   = counter_q;
    assign Acc_out   = acc_q;
    assign carry     = carry_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == StHalt);

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        ir_opc_d    = ir_opc_q;
        ir_addr_d   = ir_addr_q;
        mem_we      = 1'b0;
        mem_waddr   = counter_q;
        mem_wdata   = data_in;

        unique case (state_q)
            StLoad: begin
                // Run wins over a simultaneous button edge.
                if (run) begin
                    state_d   = StFetch;
                    counter_d = '0;
                end else if (RAM_button && !btn_q) begin
                    mem_we    = 1'b1;
                    counter_d = counter_q + 1'b1;
                end
            end
            StFetch: begin
                if (!run) begin
                    state_d   = StLoad;
                    counter_d = '0;
                end else begin
                    ir_opc_d  = RAM_out[DATA_WIDTH-1 -: 3];
                    ir_addr_d = RAM_out[ADDR_WIDTH-1:0];
                    counter_d = counter_q + 1'b1;
                    state_d   = StExec;
                end
            end
            StExec: begin
                state_d = run ? StFetch : StLoad;
                unique case (ir_opc_q)
                    OpHlt: if (run) state_d = StHalt;
                    OpAdd: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, operand};
                    OpSub: begin
                        acc_d   = acc_q - operand;
                        carry_d = (operand > acc_q);
                    end
                    OpSta: begin
                        mem_we    = 1'b1;
                        mem_waddr = ir_addr_q;
                        mem_wdata = acc_q;
                    end
                    OpLda: acc_d = operand;
                    OpBra: counter_d = ir_addr_q;
                    OpBrz: if (acc_q == '0) counter_d = ir_addr_q;
                    OpOut: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                    default: ;
                endcase
                // The instruction completes, but a dropped run returns to load mode.
                if (!run) counter_d = '0;
            end
            StHalt: begin
                if (!run) begin
                    state_d   = StLoad;
                    counter_d = '0;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge timer555) begin
        if (reset_count) begin
            state_q     <= StLoad;
            counter_q   <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ir_opc_q    <= '0;
            ir_addr_q   <= '0;
            btn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ir_opc_q    <= ir_opc_d;
            ir_addr_q   <= ir_addr_d;
            btn_q       <= RAM_button;
        end
    end

    // RAM is never cleared; reset only blocks a write in its own cycle.
    always_ff @(posedge timer555) begin
        if (mem_we && !reset_count) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_lmc_r60.sv
module tb_lmc_r60;

    logic       timer555 = 1'b0;
    logic       reset_count, run, RAM_button;
    logic [7:0] data_in;
    logic [3:0] counter;
    logic [7:0] RAM_out, Acc_out, out_data;
    logic       carry, out_valid, halted;

    lmc_r60 #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .timer555   (timer555),
        .reset_count(reset_count),
        .run        (run),
        .RAM_button (RAM_button),
        .data_in    (data_in),
        .counter    (counter),
        .RAM_out    (RAM_out),
        .Acc_out    (Acc_out),
        .carry      (carry),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    always #5 timer555 = ~timer555;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       btn;
        logic [7:0] data;
        logic [3:0] exp_cnt;
        logic [7:0] exp_ram;
    } load_vec_t;

    load_vec_t  load_tbl[10];
    logic [7:0] prog[16];

    // Reference model state (instruction-level)
    logic [7:0] mm[16];
    logic [7:0] m_acc, m_od;
    logic       m_c, m_ov, m_halt;
    logic [3:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge timer555);
        #1;
    endtask

    task automatic do_reset();
        reset_count = 1'b1;
        run         = 1'b0;
        RAM_button  = 1'b0;
        tick();
        tick();
        reset_count = 1'b0;
    endtask

    task automatic press(input logic [7:0] d);
        data_in    = d;
        RAM_button = 1'b1;
        tick();
        RAM_button = 1'b0;
        tick();
    endtask

    task automatic load_prog();
        do_reset();
        for (int i = 0; i < 16; i++) press(prog[i]);
    endtask

    task automatic exec_instr();
        tick();
        tick();
    endtask

    // Executes one whole instruction on the model.
    task automatic model_step();
        logic [7:0] w;
        logic [3:0] a;
        logic [8:0] sum;
        w      = mm[m_pc];
        a      = w[3:0];
        m_pc   = m_pc + 4'd1;
        m_ov   = 1'b0;
        m_halt = 1'b0;
        case (w[7:5])
            3'd0: m_halt = 1'b1;
            3'd1: begin
                sum   = {1'b0, m_acc} + {1'b0, mm[a]};
                m_acc = sum[7:0];
                m_c   = sum[8];
            end
            3'd2: begin
                m_c   = (mm[a] > m_acc);
                m_acc = m_acc - mm[a];
            end
            3'd3: mm[a] = m_acc;
            3'd4: m_acc = mm[a];
            3'd5: m_pc = a;
            3'd6: if (m_acc == 8'd0) m_pc = a;
            default: begin
                m_od = m_acc;
                m_ov = 1'b1;
            end
        endcase
    endtask

    task automatic run_random(input int seed_idx);
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        load_prog();
        chk($sformatf("rnd%0d load wrap", seed_idx), {RAM_out, 4'h0, counter}, {prog[0], 8'h00});
        for (int i = 0; i < 16; i++) mm[i] = prog[i];
        m_acc = 8'd0; m_c = 1'b0; m_od = 8'd0; m_pc = 4'd0; m_halt = 1'b0;
        run = 1'b1;
        tick();
        for (int k = 0; k < 40 && !m_halt; k++) begin
            tick();
            chk($sformatf("rnd%0d fetch ov", seed_idx), out_valid, 1'b0);
            tick();
            model_step();
            chk($sformatf("rnd%0d i%0d state", seed_idx, k),
                {Acc_out, out_data, 3'b0, carry, counter, 2'b0, out_valid, halted},
                {m_acc, m_od, 3'b0, m_c, m_pc, 2'b0, m_ov, m_halt});
        end
        run = 1'b0;
        tick();
        chk($sformatf("rnd%0d drop run", seed_idx), {Acc_out, 3'b0, halted, counter},
            {m_acc, 4'h0, 4'h0});
    endtask

    initial begin
        load_tbl[0] = '{1'b1, 8'h8E, 4'd1, 8'hA1};
        load_tbl[1] = '{1'b1, 8'h8E, 4'd1, 8'hA1};
        load_tbl[2] = '{1'b1, 8'h8E, 4'd1, 8'hA1};
        load_tbl[3] = '{1'b0, 8'h8E, 4'd1, 8'hA1};
        load_tbl[4] = '{1'b1, 8'h2D, 4'd2, 8'hA2};
        load_tbl[5] = '{1'b0, 8'h2D, 4'd2, 8'hA2};
        load_tbl[6] = '{1'b1, 8'hE0, 4'd3, 8'hA3};
        load_tbl[7] = '{1'b0, 8'hE0, 4'd3, 8'hA3};
        load_tbl[8] = '{1'b1, 8'h00, 4'd4, 8'hA4};
        load_tbl[9] = '{1'b0, 8'h00, 4'd4, 8'hA4};

        reset_count = 1'b1; run = 1'b0; RAM_button = 1'b0; data_in = 8'h00;

        // Reset
        do_reset();
        chk("reset", {counter, Acc_out, 1'b0, carry, out_valid, halted}, {4'h0, 8'h00, 4'h0});

        // Prefill every address with a known word; counter wraps back to 0
        for (int i = 0; i < 16; i++) press(8'hA0 + 8'(i));
        chk("prefill wrap", {RAM_out, 4'h0, counter}, {8'hA0, 8'h00});

        // Load: one write per press, first press held three cycles
        for (int i = 0; i < 10; i++) begin
            data_in    = load_tbl[i].data;
            RAM_button = load_tbl[i].btn;
            tick();
            chk($sformatf("load row%0d", i), {RAM_out, 4'h0, counter},
                {load_tbl[i].exp_ram, 4'h0, load_tbl[i].exp_cnt});
        end
        for (int i = 4; i < 13; i++) press(8'hF0);
        chk("filler cnt", counter, 4'd13);
        press(8'h05);
        press(8'h03);
        chk("load 13/14", {RAM_out, 4'h0, counter}, {8'hAF, 4'h0, 4'd15});

        // Program run: LDA 14, ADD 13, OUT, HLT
        run = 1'b1;
        tick();
        chk("run start cnt", counter, 4'd0);
        tick();
        chk("first fetch cnt", counter, 4'd1);
        tick();
        chk("lda", Acc_out, 8'h03);
        exec_instr();
        chk("add", {Acc_out, 3'b0, carry}, {8'h08, 4'h0});
        exec_instr();
        chk("out", {out_data, 3'b0, out_valid}, {8'h08, 4'h1});
        tick();
        chk("out pulse end", out_valid, 1'b0);
        tick();
        chk("hlt", {3'b0, halted, counter}, {4'h1, 4'd4});
        tick();
        chk("hlt held", {3'b0, halted, counter, Acc_out}, {4'h1, 4'd4, 8'h08});
        run = 1'b0;
        tick();
        chk("drop in halt", {3'b0, halted, counter, Acc_out}, {4'h0, 4'd0, 8'h08});

        // Overflow / branch
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h8A; prog[1] = 8'h2B; prog[2] = 8'hC7; prog[7] = 8'h4B;
        prog[8] = 8'hC3; prog[9] = 8'h00; prog[10] = 8'hFF; prog[11] = 8'h01;
        load_prog();
        run = 1'b1;
        tick();
        exec_instr();
        chk("ovf lda", Acc_out, 8'hFF);
        exec_instr();
        chk("ovf add", {Acc_out, 3'b0, carry}, {8'h00, 4'h1});
        exec_instr();
        chk("brz taken", counter, 4'd7);
        exec_instr();
        chk("sub borrow", {Acc_out, 3'b0, carry}, {8'hFF, 4'h1});
        exec_instr();
        chk("brz not taken", counter, 4'd9);
        exec_instr();
        chk("ovf halt", halted, 1'b1);
        run = 1'b0;
        tick();

        // Wrap: 17 presses
        do_reset();
        for (int i = 0; i < 15; i++) press(8'h30 + 8'(i));
        chk("wrap cnt15", counter, 4'd15);
        press(8'h3F);
        chk("wrap cnt0", counter, 4'd0);
        press(8'h5A);
        chk("wrap cnt1", counter, 4'd1);
        reset_count = 1'b1;
        tick();
        reset_count = 1'b0;
        chk("wrap mem0", {RAM_out, 4'h0, counter}, {8'h5A, 8'h00});

        // Self-modifying code: STA rewrites the next instruction to OUT
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h85; prog[1] = 8'h62; prog[5] = 8'hE0;
        load_prog();
        run = 1'b1;
        tick();
        exec_instr();
        exec_instr();
        exec_instr();
        chk("self-mod out", {out_data, 3'b0, out_valid, 3'b0, halted}, {8'hE0, 4'h1, 4'h0});
        exec_instr();
        chk("self-mod halt", halted, 1'b1);
        run = 1'b0;
        tick();

        // Reset during EXEC of STA drops the write
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h85; prog[1] = 8'hE0; prog[2] = 8'h86; prog[3] = 8'h65;
        prog[5] = 8'h11; prog[6] = 8'h99;
        load_prog();
        run = 1'b1;
        tick();
        exec_instr();
        exec_instr();
        chk("pre-reset out", out_data, 8'h11);
        exec_instr();
        tick();
        reset_count = 1'b1;
        tick();
        reset_count = 1'b0;
        chk("mid reset", {counter, 3'b0, carry, Acc_out, 2'b0, out_valid, halted},
            {4'h0, 4'h0, 8'h00, 4'h0});
        tick();
        chk("restart cnt", counter, 4'd0);
        exec_instr();
        chk("restart lda", Acc_out, 8'h11);
        tick();
        tick();
        chk("sta dropped", {out_data, 3'b0, out_valid}, {8'h11, 4'h1});
        run = 1'b0;
        tick();

        // Randomized programs against the instruction-level model
        for (int s = 0; s < 12; s++) run_random(s);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lmc_r60.md
# lmc_r60

Parametrised successor to the R10/R50 Little-Man-Computer trainer core. It holds a register-file program RAM that is loaded by push-button at the address `counter`, and it runs a stored program on an accumulator. The 3-bit instruction set covers HLT, ADD, SUB, STA, LDA, BRA, BRZ and OUT. It sits between the front-panel inputs (`RAM_button`, `data_in`, run switch) and the display/LED outputs, clocked from the 555 timer.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width; depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 8: word, accumulator and output width.
  - Legal range: DATA_WIDTH ≥ ADDR_WIDTH+3.
  - Opcode is `word[DATA_WIDTH-1 -: 3]`; operand address is `word[ADDR_WIDTH-1:0]`; any remaining middle bits are ignored.

Ports:
- `timer555` in 1: system clock; all state updates on the rising edge.
- `reset_count` in 1: reset, synchronous, active-high.
- `run` in 1: 0 = load mode, 1 = run mode; level-sensitive.
- `RAM_button` in 1: load strobe; write on a sampled rising edge.
- `data_in` in DATA_WIDTH: word to load.
- `counter` out ADDR_WIDTH: load address in LOAD, program counter otherwise.
- `RAM_out` out DATA_WIDTH: `mem[counter]`, combinational read.
- `Acc_out` out DATA_WIDTH: accumulator.
- `carry` out 1: carry of the last ADD, or borrow of the last SUB.
- `out_data` out DATA_WIDTH: value latched by OUT.
- `out_valid` out 1: one-cycle pulse per OUT.
- `halted` out 1: high in the HALT state.

## Operation
- States: LOAD, FETCH, EXEC, HALT.
- Reset:
  - state ← LOAD.
  - `counter`, `Acc_out`, `carry`, `out_data`, `out_valid`, `halted` and `ir` ← 0; `btn_q` ← 0.
  - RAM contents are **not** cleared.
- LOAD:
  - `btn_q` ← `RAM_button` every cycle.
  - If `RAM_button`=1, `btn_q`=0 and `run`=0: `mem[counter]` ← `data_in`, and `counter` ← `counter`+1, wrapping from 2^ADDR_WIDTH−1 to 0.
  - Holding the button writes exactly once.
  - If `run`=1: go to FETCH with no write that cycle (run beats a simultaneous button edge), and `counter` ← 0.
- FETCH: `ir` ← `mem[counter]`; `counter` ← `counter`+1 (wraps); go to EXEC.
- EXEC: decode `ir`, with `op` = operand address. Next state is FETCH unless stated.
  - 000 HLT: go to HALT.
  - 001 ADD: {`carry`,`acc`} ← `acc` + `mem[op]`.
  - 010 SUB: `acc` ← `acc` − `mem[op]`, mod 2^DATA_WIDTH; `carry` ← 1 iff `mem[op]` > `acc` (borrow).
  - 011 STA: `mem[op]` ← `acc`.
  - 100 LDA: `acc` ← `mem[op]`; `carry` unchanged.
  - 101 BRA: `counter` ← `op`.
  - 110 BRZ: `counter` ← `op` if `acc`==0; otherwise unchanged.
  - 111 OUT: `out_data` ← `acc`; `out_valid` ← 1 for one cycle.
- HALT: `halted`=1; all state is held.
- Leaving run mode: `run`=0 in FETCH, EXEC or HALT → LOAD next cycle.
  - An instruction in EXEC completes first, then the FSM goes to LOAD instead of FETCH.
  - On entering LOAD: `counter` ← 0 and `halted` ← 0; `acc` is kept.
- Arithmetic is unsigned modulo 2^DATA_WIDTH. Self-modifying code is legal: a FETCH reads RAM after any STA from the previous EXEC.

## Timing
- Every instruction takes 2 cycles (FETCH + EXEC). Results are visible on outputs the cycle after the EXEC edge.
- `out_valid` is registered: high for the single cycle following the OUT EXEC edge, otherwise 0.
- A load write is visible on `RAM_out`/`counter` one cycle after the edge that samples the button rise.
- Run start: `run` sampled high in LOAD → FETCH at the next edge; the first EXEC is one cycle after that.
- Reset mid-operation has priority over everything: state LOAD next cycle and no RAM write that cycle (a pending STA is dropped).
  - If `run` is still high, execution restarts from address 0 one cycle later.

## Test plan
All scenarios use ADDR_WIDTH=4, DATA_WIDTH=8.
- **Reset:** assert `reset_count` 2 cycles → `counter`=0, `Acc_out`=0, `carry`=0, `out_valid`=0, `halted`=0, state LOAD.
- **Load:** `run`=0; press the button with `data_in` 0x8E, 0x2D, 0xE0, 0x00, holding the first press 3 cycles; then load 0x05 at addr 13 and 0x03 at addr 14 (filler writes between) → exactly one write per press, `counter` steps 0→1→2→3→4, and `RAM_out` echoes each word.
- **Program run:** with the load above, raise `run` → LDA 14, ADD 13, OUT gives `out_data`=0x08 with `out_valid` high exactly one cycle, `carry`=0. HLT then gives `halted`=1 and `counter`=4 held.
- **Overflow/branch:** `acc`=0xFF, ADD a word of 0x01 → `acc`=0x00, `carry`=1; BRZ 7 jumps, so `counter`=7. SUB 0x01 from 0 → `acc`=0xFF, `carry`=1. BRZ with `acc`=0xFF falls through.
- **Wrap and self-modify:** 17 button presses → `counter` goes 15→0→1, and `mem[0]` holds the 17th word. A program doing STA to the next instruction address executes the stored value.
- **Reset mid-run / run drop:** `reset_count` during EXEC of STA → no RAM change, `acc`=0, restart at 0 with `run`=1. Dropping `run` in HALT → LOAD next cycle, `halted`=0, `counter`=0.
